mux_pipe_reg: RTL and testbench
===============================

MUX_PIPE_REG -- requirements
Module: mux_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits (1..64).
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning number of pipeline stages (1..16).
REQ-003 The block SHALL have parameter INIT, default all-ones of WIDTH, meaning the preset data value.
REQ-004 The block SHALL have port CK  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port GSR  input  1  meaning the reset, asynchronous and active-low.
REQ-006 The block SHALL have port D0  input  WIDTH  meaning data source selected when SD=0.
REQ-007 The block SHALL have port D1  input  WIDTH  meaning data source selected when SD=1.
REQ-008 The block SHALL have port SD  input  1  meaning the source select.
REQ-009 The block SHALL have port SP  input  1  meaning clock enable/advance; when low, all state holds.
REQ-010 The block SHALL have port PD  input  1  meaning synchronous preset of the stage-0 data to INIT.
REQ-011 The block SHALL have port VI  input  1  meaning input-valid qualifier for stage 0.
REQ-012 The block SHALL have port FLUSH  input  1  meaning synchronous clear of all valid flags.
REQ-013 The block SHALL have port Q  output  WIDTH  meaning last-stage data.
REQ-014 The block SHALL have port VO  output  1  meaning last-stage valid.
REQ-015 The block SHALL have port CNT  output  clog2(DEPTH+1)  meaning the number of stages currently holding valid data.

Function
REQ-016 Stage-0 next data SHALL be INIT when PD=1, otherwise D1 when SD=1, otherwise D0, captured only when SP=1.
REQ-017 PD SHALL force stage-0 valid to 1 regardless of VI when SP=1.
REQ-018 When SP=1, stage k (k>=1) SHALL capture stage k-1 data and valid; latency from D0/D1 to Q SHALL be exactly DEPTH enabled edges.
REQ-019 When SP=0, all data, valid flags and CNT SHALL hold, except as specified for FLUSH.
REQ-020 FLUSH=1 SHALL clear every valid flag and set CNT to 0 on the next edge, regardless of SP; data registers SHALL hold.
REQ-021 FLUSH SHALL take priority over PD and VI on the same edge; the newly presented word SHALL be discarded.
REQ-022 Invalid stages SHALL still shift their data when SP=1; Q SHALL show the raw last-stage data whatever the value of VO.
REQ-023 CNT SHALL update on each enabled edge as CNT + in_valid − out_valid, where in_valid = VI|PD and out_valid = last-stage valid before the edge.
REQ-024 CNT SHALL saturate at DEPTH and never wrap.
REQ-025 With DEPTH=1, Q SHALL be stage 0 directly and CNT SHALL be 1 bit wide.

Reset
REQ-026 GSR=0 SHALL immediately, without waiting for CK, set all data registers to 0, all valid flags to 0, VO=0, Q=0 and CNT=0.
REQ-027 Release of GSR SHALL be sampled synchronously: the first edge with GSR=1 SHALL perform a normal update.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight data, with no partial shift.

Verification
REQ-029 Scenario: WIDTH=8, DEPTH=3, SP=1, VI=1, SD=0, D0=0x11,0x22,0x33 on consecutive edges -> Q=0x11 with VO=1 after the 3rd edge, then 0x22 and 0x33; CNT=3.
REQ-030 Scenario: SD=1, D1=0xA5, D0=0x5A, PD=1 for one edge -> Q=0xFF (INIT) after 3 edges with VO=1; with PD=0 the next word -> Q=0xA5.
REQ-031 Scenario: pipeline full (CNT=3), SP=0 for 5 edges with D0 toggling -> Q, VO and CNT unchanged; SP=1 resumes with no lost or duplicated word.
REQ-032 Scenario: CNT=2, FLUSH=1 with SP=0 -> next edge CNT=0 and VO=0, Q data unchanged; FLUSH together with VI=1 -> CNT stays 0.
REQ-033 Scenario: GSR pulled low between edges while CNT=3 -> Q=0x00, VO=0 and CNT=0 before the next CK edge; after release, the first edge loads normally.
REQ-034 Scenario: DEPTH=1, VI alternating 1/0 -> VO follows VI with 1-edge latency and CNT toggles between 1 and 0.

Source files
------------

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: two-input muxed, enable-gated pipeline with per-stage valid
// flags and an occupancy counter.
//
// Parameters
//   WIDTH  data width in bits (1..64)
//   DEPTH  number of pipeline stages (1..16)
//   INIT   value loaded into stage 0 by PD
//
// Ports
//   CK     clock, rising edge
//   GSR    asynchronous active-low reset
//   D0/D1  data sources, SD selects D1 when high
//   SP     advance enable; when low all state holds (FLUSH still acts)
//   PD     load INIT into stage 0 and mark it valid
//   VI     input-valid qualifier for stage 0
//   FLUSH  clear all valid flags and the counter; data registers hold
//   Q      raw last-stage data (shown regardless of VO)
//   VO     last-stage valid
//   CNT    number of stages currently holding valid data
module mux_pipe_reg #(
  parameter int unsigned          WIDTH = 8,
  parameter int unsigned          DEPTH = 3,
  parameter logic [WIDTH-1:0]     INIT  = '1
) (
  input  logic                       CK,
  input  logic                       GSR,
  input  logic [WIDTH-1:0]           D0,
  input  logic [WIDTH-1:0]           D1,
  input  logic                       SD,
  input  logic                       SP,
  input  logic                       PD,
  input  logic                       VI,
  input  logic                       FLUSH,
  output logic [WIDTH-1:0]           Q,
  output logic                       VO,
  output logic [$clog2(DEPTH+1)-1:0] CNT
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] stage0_d;
  logic             in_valid;
  logic             out_valid;
  logic [CW:0]      cnt_sum;
  logic [CW-1:0]    cnt_next;

  always_comb begin
    stage0_d = D0;
    if (PD)
      stage0_d = INIT;
    else if (SD)
      stage0_d = D1;
  end

  assign in_valid  = VI | PD;
  assign out_valid = valid_q[DEPTH-1];

  // One extra bit of headroom so the increment cannot wrap before the clamp.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + {{CW{1'b0}}, in_valid};
    if (out_valid && (cnt_sum != '0))
      cnt_sum = cnt_sum - (CW+1)'(1);
    if (cnt_sum > (CW+1)'(DEPTH))
      cnt_next = CW'(DEPTH);
    else
      cnt_next = cnt_sum[CW-1:0];
  end

  always_ff @(posedge CK or negedge GSR) begin
    if (!GSR) begin
      for (int unsigned k = 0; k < DEPTH; k++)
        data_q[k] <= '0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (FLUSH) begin
      // Flush wins over PD/VI and ignores SP; the data path deliberately holds.
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (SP) begin
      data_q[0]  <= stage0_d;
      valid_q[0] <= in_valid;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        data_q[k]  <= data_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
      cnt_q <= cnt_next;
    end
  end

  assign Q   = data_q[DEPTH-1];
  assign VO  = valid_q[DEPTH-1];
  assign CNT = cnt_q;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Testbench for mux_pipe_reg: a DEPTH=3 instance checked through an
// expected-word queue plus directed state checks, and a DEPTH=1 instance
// checked with directed vectors.
module tb_mux_pipe_reg;

  logic       CK = 1'b0;
  logic       GSR = 1'b1;
  logic [7:0] D0 = '0, D1 = '0;
  logic       SD = 1'b0, SP = 1'b0, PD = 1'b0, VI = 1'b0, FLUSH = 1'b0;

  logic [7:0] Q;
  logic       VO;
  logic [1:0] CNT;
  logic [7:0] Q1;
  logic       VO1;
  logic       CNT1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 CK = ~CK;

  mux_pipe_reg #(.WIDTH(8), .DEPTH(3), .INIT(8'hFF)) dut (
    .CK(CK), .GSR(GSR), .D0(D0), .D1(D1), .SD(SD), .SP(SP), .PD(PD),
    .VI(VI), .FLUSH(FLUSH), .Q(Q), .VO(VO), .CNT(CNT)
  );

  mux_pipe_reg #(.WIDTH(8), .DEPTH(1), .INIT(8'hFF)) dut1 (
    .CK(CK), .GSR(GSR), .D0(D0), .D1(D1), .SD(SD), .SP(SP), .PD(PD),
    .VI(VI), .FLUSH(FLUSH), .Q(Q1), .VO(VO1), .CNT(CNT1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inputs for the next edge and record the word it should deliver.
  task automatic apply(input logic sp, input logic vi, input logic pd, input logic sd,
                       input logic [7:0] d0, input logic [7:0] d1, input logic fl);
    SP = sp; VI = vi; PD = pd; SD = sd; D0 = d0; D1 = d1; FLUSH = fl;
    if (fl)
      exp_q.delete();
    else if (GSR && sp && (vi || pd))
      exp_q.push_back(pd ? 8'hFF : (sd ? d1 : d0));
  endtask

  task automatic tick();
    @(negedge CK);
  endtask

  task automatic chk_st(input string name, input logic [1:0] cnt, input logic vo);
    chk({name, "_cnt"}, CNT, cnt);
    chk({name, "_vo"}, VO, vo);
  endtask

  // Monitor: after every advancing edge with VO high, the oldest expected word must appear.
  initial begin
    logic adv;
    logic [7:0] e;
    forever begin
      @(posedge CK);
      adv = GSR && SP && !FLUSH;
      #2;
      if (adv && VO) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h expected=none", Q);
        end else begin
          e = exp_q.pop_front();
          chk("sb_q", Q, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Asynchronous reset with no clock edge in between.
    #2 GSR = 1'b0;
    #1;
    chk("rst_q", Q, 8'h00);
    chk_st("rst", 2'd0, 1'b0);
    chk("rst1_q", Q1, 8'h00);
    chk("rst1_vo", VO1, 1'b0);
    chk("rst1_cnt", CNT1, 1'b0);
    tick();
    GSR = 1'b1;
    apply(0, 0, 0, 0, 8'h00, 8'h00, 0);
    tick();

    // Basic fill through D0.
    apply(1, 1, 0, 0, 8'h11, 8'h00, 0); tick(); chk_st("fill1", 2'd1, 1'b0);
    apply(1, 1, 0, 0, 8'h22, 8'h00, 0); tick(); chk_st("fill2", 2'd2, 1'b0);
    apply(1, 1, 0, 0, 8'h33, 8'h00, 0); tick(); chk_st("fill3", 2'd3, 1'b1);
    chk("fill3_q", Q, 8'h11);

    // Full pipeline stalled while D0 toggles.
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0, (i % 2 == 1) ? 8'hAA : 8'h55, 8'h00, 0);
      tick();
      chk("hold_q", Q, 8'h11);
      chk_st("hold", 2'd3, 1'b1);
    end
    apply(1, 1, 0, 0, 8'h44, 8'h00, 0); tick(); chk_st("res1", 2'd3, 1'b1);
    chk("res1_q", Q, 8'h22);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("res2", 2'd2, 1'b1);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("res3", 2'd1, 1'b1);
    chk("res3_q", Q, 8'h44);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("res4", 2'd0, 1'b0);

    // Preset beats the mux, then D1 selected.
    apply(1, 1, 1, 1, 8'h5A, 8'hA5, 0); tick(); chk_st("pd1", 2'd1, 1'b0);
    apply(1, 1, 0, 1, 8'h5A, 8'hA5, 0); tick(); chk_st("pd2", 2'd2, 1'b0);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("pd3", 2'd2, 1'b1);
    chk("pd3_q", Q, 8'hFF);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("pd4", 2'd1, 1'b1);
    chk("pd4_q", Q, 8'hA5);
    apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick(); chk_st("pd5", 2'd0, 1'b0);
    chk("raw_q", Q, 8'h77);

    // Flush while stalled, then flush against VI and PD.
    apply(1, 1, 0, 0, 8'hB1, 8'h00, 0); tick();
    apply(1, 1, 0, 0, 8'hB2, 8'h00, 0); tick(); chk_st("pre_fl", 2'd2, 1'b0);
    apply(0, 0, 0, 0, 8'h00, 8'h00, 1); tick(); chk_st("fl1", 2'd0, 1'b0);
    chk("fl1_q", Q, 8'h77);
    apply(1, 1, 1, 0, 8'hC3, 8'h00, 1); tick(); chk_st("fl2", 2'd0, 1'b0);
    chk("fl2_q", Q, 8'h77);
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 0, 0, 8'h77, 8'h00, 0); tick();
      chk_st("post_fl", 2'd0, 1'b0);
    end

    // Reset mid-operation, between edges.
    apply(1, 1, 0, 0, 8'hD1, 8'h00, 0); tick();
    apply(1, 1, 0, 0, 8'hD2, 8'h00, 0); tick();
    apply(1, 1, 0, 0, 8'hD3, 8'h00, 0); tick(); chk_st("pre_rst", 2'd3, 1'b1);
    GSR = 1'b0;
    exp_q.delete();
    apply(1, 1, 0, 0, 8'hE0, 8'h00, 0);
    #1;
    chk("mid_rst_q", Q, 8'h00);
    chk_st("mid_rst", 2'd0, 1'b0);
    tick();
    chk_st("in_rst", 2'd0, 1'b0);
    GSR = 1'b1;
    apply(1, 1, 0, 0, 8'hE1, 8'h00, 0); tick(); chk_st("rel1", 2'd1, 1'b0);
    apply(1, 0, 0, 0, 8'h00, 8'h00, 0); tick(); chk_st("rel2", 2'd1, 1'b0);
    apply(1, 0, 0, 0, 8'h00, 8'h00, 0); tick(); chk_st("rel3", 2'd1, 1'b1);
    chk("rel3_q", Q, 8'hE1);

    // DEPTH=1 instance: VO follows VI one edge later, CNT never exceeds 1.
    apply(1, 1, 0, 0, 8'h61, 8'h00, 0); tick();
    chk("d1a_vo", VO1, 1'b1); chk("d1a_cnt", CNT1, 1'b1); chk("d1a_q", Q1, 8'h61);
    apply(1, 0, 0, 0, 8'h62, 8'h00, 0); tick();
    chk("d1b_vo", VO1, 1'b0); chk("d1b_cnt", CNT1, 1'b0); chk("d1b_q", Q1, 8'h62);
    apply(1, 1, 0, 0, 8'h63, 8'h00, 0); tick();
    chk("d1c_vo", VO1, 1'b1); chk("d1c_cnt", CNT1, 1'b1);
    apply(1, 1, 0, 0, 8'h64, 8'h00, 0); tick();
    chk("d1d_vo", VO1, 1'b1); chk("d1d_cnt", CNT1, 1'b1); chk("d1d_q", Q1, 8'h64);
    apply(1, 0, 0, 0, 8'h65, 8'h00, 0); tick();
    chk("d1e_vo", VO1, 1'b0); chk("d1e_cnt", CNT1, 1'b0);

    // Drain the DEPTH=3 pipeline; every recorded word must have emerged.
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 0, 8'h00, 8'h00, 0); tick();
    end
    chk_st("drain", 2'd0, 1'b0);
    chk("sb_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
